mem_access_ctrl: RTL and testbench

Sequencing controller on the initiator side of the 8-bit latch memory bank. It drives the `op` / `sel` / `in_bus` pins of up to eight `Memory_unit` instances and samples their shared `out_bus`. It turns single host read/write requests into correctly ordered setup, strobe and hold phases, and returns one response per request through a valid/ready handshake. It sits between the datapath and the memory bank, so the bank never sees glitching selects or unstable data while a latch is open.

---
 rtl/mem_access_ctrl_if.sv | 26 ++
 rtl/mem_access_ctrl.sv | 103 ++++++++++
 tb/tb_mem_access_ctrl.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Host request/response and memory-bank pins of mem_access_ctrl, bundled for port connection.
// slave = controller view; master = host and memory-bank view.
interface mem_access_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       mem_op;
  logic [7:0] mem_sel;
  logic [7:0] mem_in_bus;
  logic [7:0] mem_out_bus;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_out_bus,
    output req_ready, rsp_valid, rsp_data, mem_op, mem_sel, mem_in_bus
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_out_bus,
    input  req_ready, rsp_valid, rsp_data, mem_op, mem_sel, mem_in_bus
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Sequences single read/write accesses to the 8-unit latch bank.
// Each access runs setup, strobe and hold phases, then returns one response.
module mem_access_ctrl #(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] addr_q, addr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       mem_op_q, mem_op_d;
  logic [7:0] mem_sel_q, mem_sel_d;
  logic [7:0] mem_in_q, mem_in_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 3'd0;
      cnt_q      <= 4'd0;
      rsp_data_q <= 8'h00;
      mem_op_q   <= 1'b0;
      mem_sel_q  <= 8'h00;
      mem_in_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      mem_op_q   <= mem_op_d;
      mem_sel_q  <= mem_sel_d;
      mem_in_q   <= mem_in_d;
    end
  end

  // mem_op and mem_in_bus are loaded at acceptance and held through HOLD,
  // so they are stable before sel rises and after it falls.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    mem_op_d   = mem_op_q;
    mem_sel_d  = mem_sel_q;
    mem_in_d   = mem_in_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          mem_op_d = bus.req_we;
          mem_in_d = bus.req_we ? bus.req_wdata : 8'h00;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d     = CNT_LOAD;
        mem_sel_d = 8'h01 << addr_q;
        state_d   = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          mem_sel_d  = 8'h00;
          rsp_data_d = mem_op_q ? 8'h00 : bus.mem_out_bus;
          state_d    = S_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        mem_op_d = 1'b0;
        mem_in_d = 8'h00;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_data   = rsp_data_q;
  assign bus.mem_op     = mem_op_q;
  assign bus.mem_sel    = mem_sel_q;
  assign bus.mem_in_bus = mem_in_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Drives three controllers (strobe 2, 1, 15) with identical requests, each against its own
// latch-bank model, and compares responses, latency and strobe shape against a scoreboard.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [2:0] req_addr = 3'd0;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         snap[3];

  logic       rdy_w[3], vld_w[3], op_w[3], multi_w[3], opchg_w[3];
  logic       sel_op_w[3], hold_op_w[3];
  logic [7:0] data_w[3], sel_w[3], inb_w[3], cap_w[3], sel_in_w[3], hold_in_w[3];
  int         lat_w[3], width_w[3], rc_w[3], sel_total_w[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ns(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int N = (gi == 0) ? 2 : ((gi == 1) ? 1 : 15);

    mem_access_ctrl_if bus();
    logic [7:0] mem [8] = '{default: 8'h00};

    int         acc_c = 0, lat = 0, width = 0, rsp_cnt = 0, sel_total = 0;
    logic       multi = 1'b0, opchg = 1'b0, prev_vld = 1'b0, prev_op = 1'b0;
    logic       sel_op = 1'b0, hold_op = 1'b0;
    logic [7:0] prev_sel = 8'h00, cap = 8'h00, sel_in = 8'h00, hold_in = 8'h00;

    assign bus.req_valid = req_valid;
    assign bus.req_we    = req_we;
    assign bus.req_addr  = req_addr;
    assign bus.req_wdata = req_wdata;
    assign bus.rsp_ready = rsp_ready;

    always_comb begin
      bus.mem_out_bus = 8'h00;
      for (int i = 0; i < 8; i++)
        if (bus.mem_sel[i]) bus.mem_out_bus = mem[i];
    end

    always @(posedge clk)
      for (int i = 0; i < 8; i++)
        if (bus.mem_sel[i] && bus.mem_op) mem[i] <= bus.mem_in_bus;

    mem_access_ctrl #(.STROBE_CYCLES(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    // Per-cycle observer: latency, strobe width, bus values while selected and in hold.
    always @(posedge clk) begin
      if (bus.req_valid && bus.req_ready) begin
        acc_c <= cyc;
        width <= 0;
      end
      if (bus.mem_sel != 8'h00) begin
        width     <= width + 1;
        sel_total <= sel_total + 1;
        sel_op    <= bus.mem_op;
        sel_in    <= bus.mem_in_bus;
        if ($countones(bus.mem_sel) > 1) multi <= 1'b1;
        if (prev_sel != 8'h00 && bus.mem_op != prev_op) opchg <= 1'b1;
      end
      if (prev_sel != 8'h00 && bus.mem_sel == 8'h00) begin
        hold_op <= bus.mem_op;
        hold_in <= bus.mem_in_bus;
      end
      if (bus.rsp_valid && !prev_vld) lat <= cyc - acc_c;
      if (bus.rsp_valid && bus.rsp_ready) begin
        cap     <= bus.rsp_data;
        rsp_cnt <= rsp_cnt + 1;
      end
      prev_sel <= bus.mem_sel;
      prev_op  <= bus.mem_op;
      prev_vld <= bus.rsp_valid;
    end

    assign rdy_w[gi]       = bus.req_ready;
    assign vld_w[gi]       = bus.rsp_valid;
    assign data_w[gi]      = bus.rsp_data;
    assign op_w[gi]        = bus.mem_op;
    assign sel_w[gi]       = bus.mem_sel;
    assign inb_w[gi]       = bus.mem_in_bus;
    assign lat_w[gi]       = lat;
    assign width_w[gi]     = width;
    assign rc_w[gi]        = rsp_cnt;
    assign sel_total_w[gi] = sel_total;
    assign cap_w[gi]       = cap;
    assign multi_w[gi]     = multi;
    assign opchg_w[gi]     = opchg;
    assign sel_op_w[gi]    = sel_op;
    assign sel_in_w[gi]    = sel_in;
    assign hold_op_w[gi]   = hold_op;
    assign hold_in_w[gi]   = hold_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle, then scrambles the request pins.
  // Returns at the negedge inside the SETUP cycle.
  task automatic issue(input logic we, input logic [2:0] a, input logic [7:0] wd,
                       input logic [7:0] rd_exp, input bit push);
    @(negedge clk);
    for (int g = 0; g < 3; g++) snap[g] = rc_w[g];
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    if (push) exp_q.push_back(we ? 8'h00 : rd_exp);
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = ~a;
    req_wdata = ~wd;
    chk("accepted", {31'd0, rdy_w[0]}, 32'd0);
  endtask

  // Waits for all three responses, then scores data, latency and strobe width.
  task automatic complete(input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    while (n < 200 && !(rc_w[0] > snap[0] && rc_w[1] > snap[1] && rc_w[2] > snap[2])) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, {31'd0, n < 200}, 32'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_data[%0d]", tag, g), {24'd0, cap_w[g]}, {24'd0, e});
      chk($sformatf("%s_latency[%0d]", tag, g), lat_w[g], ns(g) + 3);
      chk($sformatf("%s_strobe[%0d]", tag, g), width_w[g], ns(g));
      chk($sformatf("%s_ready_after[%0d]", tag, g), {31'd0, rdy_w[g]}, 32'd1);
    end
    $display("txn %s: rsp=%02h lat=%0d/%0d/%0d strobe=%0d/%0d/%0d", tag, cap_w[0],
             lat_w[0], lat_w[1], lat_w[2], width_w[0], width_w[1], width_w[2]);
  endtask

  initial begin
    int n;
    logic quiet;
    int sel_before;

    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset_ready[%0d]", g), {31'd0, rdy_w[g]}, 32'd1);
      chk($sformatf("reset_sel[%0d]", g), {24'd0, sel_w[g]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", {31'd0, rdy_w[0]}, 32'd1);
    chk("post_reset_rsp_valid", {31'd0, vld_w[0]}, 32'd0);

    // Write 0x55 to unit 3: check SETUP drive, then strobe/hold bus values.
    issue(1'b1, 3'd3, 8'h55, 8'h00, 1'b1);
    chk("w3_setup_op", {31'd0, op_w[0]}, 32'd1);
    chk("w3_setup_inbus", {24'd0, inb_w[0]}, 32'h55);
    chk("w3_setup_sel", {24'd0, sel_w[0]}, 32'h00);
    @(negedge clk);
    chk("w3_strobe_sel", {24'd0, sel_w[0]}, 32'h08);
    complete("w3");
    chk("w3_sel_op", {31'd0, sel_op_w[0]}, 32'd1);
    chk("w3_sel_inbus", {24'd0, sel_in_w[0]}, 32'h55);
    chk("w3_hold_op", {31'd0, hold_op_w[0]}, 32'd1);
    chk("w3_hold_inbus", {24'd0, hold_in_w[0]}, 32'h55);

    // Read unit 3 back; read data pins must not carry the host's wdata.
    issue(1'b0, 3'd3, 8'hEE, 8'h55, 1'b1);
    chk("r3_setup_op", {31'd0, op_w[0]}, 32'd0);
    chk("r3_setup_inbus", {24'd0, inb_w[0]}, 32'h00);
    complete("r3");
    chk("r3_sel_op", {31'd0, sel_op_w[0]}, 32'd0);
    chk("r3_sel_inbus", {24'd0, sel_in_w[0]}, 32'h00);

    // Asynchronous reset mid-idle, away from a clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("idle_rst_ready", {31'd0, rdy_w[0]}, 32'd1);
    chk("idle_rst_valid", {31'd0, vld_w[0]}, 32'd0);
    chk("idle_rst_data", {24'd0, data_w[0]}, 32'h00);
    chk("idle_rst_op", {31'd0, op_w[0]}, 32'd0);
    chk("idle_rst_sel", {24'd0, sel_w[0]}, 32'h00);
    chk("idle_rst_inbus", {24'd0, inb_w[0]}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rst_release_ready", {31'd0, rdy_w[0]}, 32'd1);

    // Isolation between unit 0 and unit 7.
    issue(1'b1, 3'd0, 8'hAA, 8'h00, 1'b1);
    complete("w0");
    issue(1'b1, 3'd7, 8'h0F, 8'h00, 1'b1);
    complete("w7");
    issue(1'b0, 3'd0, 8'h00, 8'hAA, 1'b1);
    complete("r0");
    issue(1'b0, 3'd7, 8'h00, 8'h0F, 1'b1);
    complete("r7");

    // Back-pressure on a read of unit 0, with a stray write to unit 6 offered meanwhile.
    rsp_ready = 1'b0;
    issue(1'b0, 3'd0, 8'h00, 8'hAA, 1'b1);
    n = 0;
    while (n < 50 && !vld_w[0]) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_timeout", {31'd0, n < 50}, 32'd1);
    sel_before = sel_total_w[0];
    for (int k = 0; k < 6; k++) begin
      req_we    = 1'b1;
      req_addr  = 3'd6;
      req_wdata = 8'h99;
      req_valid = (k % 2 == 0);
      @(negedge clk);
      chk($sformatf("bp_valid_%0d", k), {31'd0, vld_w[0]}, 32'd1);
      chk($sformatf("bp_data_%0d", k), {24'd0, data_w[0]}, 32'hAA);
      chk($sformatf("bp_ready_%0d", k), {31'd0, rdy_w[0]}, 32'd0);
    end
    req_valid = 1'b0;
    chk("bp_no_sel_activity", sel_total_w[0], sel_before);
    rsp_ready = 1'b1;
    complete("bp_r0");
    issue(1'b0, 3'd6, 8'h00, 8'h00, 1'b1);
    complete("r6_untouched");

    // Reset in the first strobe cycle of a write; no response may follow.
    issue(1'b1, 3'd2, 8'h77, 8'h00, 1'b0);
    @(negedge clk);
    chk("mid_strobe_sel", {24'd0, sel_w[0]}, 32'h04);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++)
      chk($sformatf("mid_rst_sel[%0d]", g), {24'd0, sel_w[g]}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++)
        if (vld_w[g] !== 1'b0 || rdy_w[g] !== 1'b1) quiet = 1'b0;
    end
    chk("mid_rst_idle_no_rsp", {31'd0, quiet}, 32'd1);

    issue(1'b0, 3'd7, 8'h00, 8'h0F, 1'b1);
    complete("r7_after_rst");

    for (int g = 0; g < 3; g++) begin
      chk($sformatf("one_hot_sel[%0d]", g), {31'd0, multi_w[g]}, 32'd0);
      chk($sformatf("op_stable_sel[%0d]", g), {31'd0, opchg_w[g]}, 32'd0);
    end
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
